// File: rtl/max7219_pkg.sv
// Shared constants and state types for the MAX7219 sequencer.
// Build option: MAX7219_CTRL_TEST_EN adds a lamp-test prefix to the init sequence.
package max7219_pkg;

   // MAX7219 register addresses
   localparam logic [7:0] REG_DIGIT0    = 8'h01;
   localparam logic [7:0] REG_DECODE    = 8'h09;
   localparam logic [7:0] REG_INTENSITY = 8'h0A;
   localparam logic [7:0] REG_SCANLIM   = 8'h0B;
   localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
   localparam logic [7:0] REG_TEST      = 8'h0F;

   localparam int INIT_WORDS = 5;
   localparam int NUM_ROWS   = 8;
   localparam int HOLD_BITS  = 20;   // lamp-test hold of 2^20 cycles

   typedef enum logic [2:0] {ST_TEST, ST_HOLD, ST_INIT, ST_IDLE, ST_SCAN} ctrl_state_e;
   typedef enum logic [2:0] {X_IDLE, X_ISSUE, X_WAIT_HI, X_WAIT_LO, X_GAP} xfer_state_e;

   // Register address of each normal init step
   function automatic logic [7:0] init_addr(input logic [2:0] step);
      case (step)
         3'd0:    init_addr = REG_TEST;
         3'd1:    init_addr = REG_DECODE;
         3'd2:    init_addr = REG_INTENSITY;
         3'd3:    init_addr = REG_SCANLIM;
         default: init_addr = REG_SHUTDOWN;
      endcase
   endfunction

endpackage

// File: rtl/max7219_xfer.sv
// One-word handshake with the MAX7219 serial driver: ISSUE -> WAIT_HI -> WAIT_LO -> GAP,
// with a watchdog on both wait states. addr/data/str are registered outputs.
module max7219_xfer
   import max7219_pkg::*;
#(
   parameter int GAP_CYC     = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [7:0] addr_i,
   input  logic [7:0] data_i,
   input  logic       busy_i,
   output logic       ready_o,
   output logic       done_o,
   output logic       timeout_o,
   output logic       str_o,
   output logic [7:0] addr_o,
   output logic [7:0] data_o
);

   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int WW = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYC - 1);

   xfer_state_e   state_q, state_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [WW-1:0] wd_q, wd_d;
   logic          str_q, str_d;
   logic [7:0]    addr_q, addr_d, data_q, data_d;
   logic          wd_hit, gap_end;

   assign wd_hit  = (wd_q == WD_LAST);
   assign gap_end = (gap_q == GAP_LAST);

   // State and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= X_IDLE;
         gap_q   <= '0;
         wd_q    <= '0;
         str_q   <= 1'b0;
         addr_q  <= 8'h00;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         wd_q    <= wd_d;
         str_q   <= str_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Next state; watchdog clears on every state change and counts only while waiting
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      wd_d    = '0;
      str_d   = str_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         X_IDLE:    if (start_i) state_d = X_ISSUE;
         X_ISSUE: begin
            // addr/data are captured together with the str rise and held until WAIT_LO ends
            state_d = X_WAIT_HI;
            str_d   = 1'b1;
            addr_d  = addr_i;
            data_d  = data_i;
         end
         X_WAIT_HI: begin
            if (busy_i) state_d = X_WAIT_LO;
            else if (wd_hit) begin
               state_d = X_GAP;
               str_d   = 1'b0;
               gap_d   = '0;
            end else wd_d = wd_q + 1'b1;
         end
         X_WAIT_LO: begin
            if (!busy_i || wd_hit) begin
               state_d = X_GAP;
               str_d   = 1'b0;
               gap_d   = '0;
            end else wd_d = wd_q + 1'b1;
         end
         X_GAP: begin
            // str low for GAP_CYC cycles lets the driver's clock generator reset
            if (gap_end) state_d = start_i ? X_ISSUE : X_IDLE;
            else gap_d = gap_q + 1'b1;
         end
         default: state_d = X_IDLE;
      endcase
   end

   // Handshake strobes to the sequencer
   always_comb begin
      ready_o   = (state_q == X_IDLE) || ((state_q == X_GAP) && gap_end);
      done_o    = (state_q == X_WAIT_LO) && !busy_i;
      timeout_o = ((state_q == X_WAIT_HI) && !busy_i && wd_hit) ||
                  ((state_q == X_WAIT_LO) &&  busy_i && wd_hit);
   end

   assign str_o  = str_q;
   assign addr_o = addr_q;
   assign data_o = data_q;

endmodule

// File: rtl/max7219_ctrl.sv
// MAX7219 sequencer: power-up register sequence, then eight digit writes per loaded frame
// from a double-buffered 64-bit image. Watchdog expiry restarts init and sets a sticky err.
// Build option: MAX7219_CTRL_TEST_EN prefixes init with a lamp-test word and a 2^20-cycle hold.
module max7219_ctrl
   import max7219_pkg::*;
#(
   parameter logic [3:0] INTENSITY   = 4'h8,
   parameter logic [2:0] SCAN_LIMIT  = 3'd7,
   parameter int         GAP_CYC     = 4,
   parameter int         TIMEOUT_CYC = 4096
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic [63:0] frame,
   input  logic        frame_load,
   output logic        init_done,
   output logic        frame_done,
   output logic        err,
   output logic        spi_str,
   input  logic        spi_busy,
   output logic [7:0]  spi_addr,
   output logic [7:0]  spi_data
);

`ifdef MAX7219_CTRL_TEST_EN
   localparam ctrl_state_e RESET_ST = ST_TEST;
`else
   localparam ctrl_state_e RESET_ST = ST_INIT;
`endif

   ctrl_state_e state_q, state_d;
   logic [2:0]  step_q, step_d;
   logic [63:0] pend_q, pend_d, act_q, act_d;
   logic        flag_q, flag_d;
   logic        init_done_q, init_done_d;
   logic        frame_done_q, frame_done_d;
   logic        err_q, err_d;
`ifdef MAX7219_CTRL_TEST_EN
   logic [HOLD_BITS-1:0] hold_q, hold_d;
`endif

   logic       xfer_start, xfer_ready, xfer_done, xfer_timeout;
   logic [7:0] word_addr, word_data;

   max7219_xfer #(
      .GAP_CYC     (GAP_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_xfer (
      .clk_i     (sys_clk),
      .rst_i     (rst),
      .start_i   (xfer_start),
      .addr_i    (word_addr),
      .data_i    (word_data),
      .busy_i    (spi_busy),
      .ready_o   (xfer_ready),
      .done_o    (xfer_done),
      .timeout_o (xfer_timeout),
      .str_o     (spi_str),
      .addr_o    (spi_addr),
      .data_o    (spi_data)
   );

   // Sequencer state, frame buffers and status flags
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q      <= RESET_ST;
         step_q       <= 3'd0;
         pend_q       <= 64'd0;
         act_q        <= 64'd0;
         flag_q       <= 1'b0;
         init_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
`ifdef MAX7219_CTRL_TEST_EN
         hold_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         pend_q       <= pend_d;
         act_q        <= act_d;
         flag_q       <= flag_d;
         init_done_q  <= init_done_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
`ifdef MAX7219_CTRL_TEST_EN
         hold_q       <= hold_d;
`endif
      end
   end

   // Next state: advance on word completion, pick up pending frames when idle
   always_comb begin
      state_d      = state_q;
      step_d       = step_q;
      pend_d       = pend_q;
      act_d        = act_q;
      flag_d       = flag_q;
      init_done_d  = init_done_q;
      frame_done_d = 1'b0;
      err_d        = err_q;
`ifdef MAX7219_CTRL_TEST_EN
      hold_d       = hold_q;
`endif
      case (state_q)
`ifdef MAX7219_CTRL_TEST_EN
         ST_TEST: if (xfer_done) begin
            state_d = ST_HOLD;
            hold_d  = '0;
         end
         ST_HOLD: begin
            if (&hold_q) state_d = ST_INIT;
            else hold_d = hold_q + 1'b1;
         end
`endif
         ST_INIT: if (xfer_done) begin
            if (step_q == 3'(INIT_WORDS - 1)) begin
               state_d     = ST_IDLE;
               step_d      = 3'd0;
               init_done_d = 1'b1;
            end else step_d = step_q + 3'd1;
         end
         ST_IDLE: if (flag_q && xfer_ready) begin
            act_d   = pend_q;
            flag_d  = 1'b0;
            state_d = ST_SCAN;
            step_d  = 3'd0;
         end
         ST_SCAN: if (xfer_done) begin
            if (step_q == 3'(NUM_ROWS - 1)) begin
               state_d      = ST_IDLE;
               step_d       = 3'd0;
               frame_done_d = 1'b1;
            end else step_d = step_q + 3'd1;
         end
         default: state_d = RESET_ST;
      endcase
      // A load wins over the idle consume so a same-cycle frame is never dropped
      if (frame_load) begin
         pend_d = frame;
         flag_d = 1'b1;
      end
      // Watchdog restart keeps the pending frame and its flag
      if (xfer_timeout) begin
         state_d      = RESET_ST;
         step_d       = 3'd0;
         err_d        = 1'b1;
         init_done_d  = 1'b0;
         frame_done_d = 1'b0;
      end
   end

   // Word to send for the current state/step
   always_comb begin
      xfer_start = 1'b0;
      word_addr  = REG_DIGIT0 + {5'd0, step_q};
      word_data  = act_q[{step_q, 3'b000} +: 8];
      case (state_q)
         ST_TEST: begin
            xfer_start = 1'b1;
            word_addr  = REG_TEST;
            word_data  = 8'h01;
         end
         ST_INIT: begin
            xfer_start = 1'b1;
            word_addr  = init_addr(step_q);
            case (step_q)
               3'd2:    word_data = {4'h0, INTENSITY};
               3'd3:    word_data = {5'h0, SCAN_LIMIT};
               3'd4:    word_data = 8'h01;
               default: word_data = 8'h00;
            endcase
         end
         ST_IDLE: xfer_start = flag_q;
         ST_SCAN: xfer_start = 1'b1;
         default: xfer_start = 1'b0;
      endcase
   end

   assign init_done  = init_done_q;
   assign frame_done = frame_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_max7219_ctrl.sv
// Randomized bench for max7219_ctrl: driver model on busy, word scoreboard built from
// the register-write rules (init list, rows of each frame).
module tb_max7219_ctrl;

   localparam int GAP_CYC = 4;
   localparam int TO_CYC  = 4096;

   logic        sys_clk, rst, frame_load, spi_busy;
   logic [63:0] frame;
   logic        init_done, frame_done, err, spi_str;
   logic [7:0]  spi_addr, spi_data;

   max7219_ctrl #(
      .INTENSITY   (4'h8),
      .SCAN_LIMIT  (3'd7),
      .GAP_CYC     (GAP_CYC),
      .TIMEOUT_CYC (TO_CYC)
   ) dut (
      .sys_clk    (sys_clk),
      .rst        (rst),
      .frame      (frame),
      .frame_load (frame_load),
      .init_done  (init_done),
      .frame_done (frame_done),
      .err        (err),
      .spi_str    (spi_str),
      .spi_busy   (spi_busy),
      .spi_addr   (spi_addr),
      .spi_data   (spi_data)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int n_chk = 0, n_err = 0;
   logic [15:0] got_q[$], exp_q[$];
   int          low_q[$];
   int          cyc = 0, rise_cyc = 0, err_cyc = 0, low_run = 0, fd_cnt = 0, stab_err = 0;
   logic        prev_str = 0, prev_err = 0, drv_en = 1;
   logic [15:0] prev_ad = 0;
   int          drv_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Driver model: busy rises 7 cycles after str, falls 120 cycles later
   always @(negedge sys_clk) begin
      if (!spi_str) begin
         drv_cnt  = 0;
         spi_busy = 1'b0;
      end else begin
         drv_cnt++;
         if (drv_cnt == 7 && drv_en) spi_busy = 1'b1;
         else if (drv_cnt == 127)    spi_busy = 1'b0;
      end
   end

   // Monitor: capture each word at the str rise, low time before it, stability, pulses
   always @(negedge sys_clk) begin
      if (rst) begin
         prev_str = 0;
         prev_err = 0;
         low_run  = 0;
      end else begin
         if (spi_str && !prev_str) begin
            got_q.push_back({spi_addr, spi_data});
            low_q.push_back(low_run);
            rise_cyc = cyc;
         end
         if (spi_str && prev_str && {spi_addr, spi_data} != prev_ad) stab_err++;
         low_run = spi_str ? 0 : low_run + 1;
         if (err && !prev_err) err_cyc = cyc;
         if (frame_done) fd_cnt++;
         prev_str = spi_str;
         prev_err = err;
         prev_ad  = {spi_addr, spi_data};
      end
      cyc++;
   end

   // Reference model: what the display should receive
   task automatic exp_init();
      exp_q.push_back({8'h0F, 8'h00});
      exp_q.push_back({8'h09, 8'h00});
      exp_q.push_back({8'h0A, 8'h08});
      exp_q.push_back({8'h0B, 8'h07});
      exp_q.push_back({8'h0C, 8'h01});
   endtask

   task automatic exp_frame(input logic [63:0] f);
      for (int r = 0; r < 8; r++) exp_q.push_back({8'(r + 1), f[8*r +: 8]});
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge sys_clk);
      #1;
   endtask

   task automatic load(input logic [63:0] f);
      @(negedge sys_clk);
      frame = f;
      frame_load = 1'b1;
      @(negedge sys_clk);
      frame_load = 1'b0;
      #1;
   endtask

   task automatic wait_words(input int n, input int budget);
      int k = 0;
      while (got_q.size() < n && k < budget) begin idle(1); k++; end
      chk("wait_words", got_q.size() >= n, 1);
   endtask

   task automatic wait_fd(input int n, input int budget);
      int k = 0;
      while (fd_cnt < n && k < budget) begin idle(1); k++; end
      chk("wait_frame_done", fd_cnt >= n, 1);
   endtask

   task automatic wait_init(input int budget);
      int k = 0;
      while (!init_done && k < budget) begin idle(1); k++; end
      chk("wait_init_done", init_done, 1);
   endtask

   task automatic wait_err(input int budget);
      int k = 0;
      while (!err && k < budget) begin idle(1); k++; end
      chk("wait_err", err, 1);
   endtask

   task automatic cmp_words(input string tag);
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk(tag, got_q[i], exp_q[i]);
         if (i > 0) chk({tag, "_gap"}, low_q[i], GAP_CYC + 1);
      end
      got_q.delete();
      low_q.delete();
      exp_q.delete();
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_str"},   spi_str,    0);
      chk({tag, "_addr"},  spi_addr,   0);
      chk({tag, "_data"},  spi_data,   0);
      chk({tag, "_init"},  init_done,  0);
      chk({tag, "_fdone"}, frame_done, 0);
      chk({tag, "_err"},   err,        0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_time_limit");
      $fatal(1);
   end

   initial begin
      logic [63:0] f, fa, fb, fx;
      int fd0;
      rst = 1'b1; frame = 64'd0; frame_load = 1'b0;
      idle(3);
      chk_reset_outs("reset");
      @(negedge sys_clk); rst = 1'b0;

      // Power-up sequence
      exp_init();
      wait_init(3000);
      idle(20);
      cmp_words("init");

      // Directed frame with load-to-str latency
      f = 64'h8142241818244281;
      @(negedge sys_clk); frame = f; frame_load = 1'b1;
      @(negedge sys_clk); frame_load = 1'b0; #1;
      chk("lat_n0", spi_str, 0);
      idle(1); chk("lat_n1", spi_str, 0);
      idle(1); chk("lat_n2", spi_str, 1);
      exp_frame(f);
      fd0 = fd_cnt;
      wait_fd(fd0 + 1, 3000);
      idle(50);
      chk("fdone_once", fd_cnt - fd0, 1);
      cmp_words("xframe");

      // Random frames
      for (int t = 0; t < 3; t++) begin
         f = {$urandom, $urandom};
         load(f);
         exp_frame(f);
         fd0 = fd_cnt;
         wait_fd(fd0 + 1, 3000);
         idle(50);
         chk("fdone_rand", fd_cnt - fd0, 1);
         cmp_words("rframe");
      end

      // Two loads during a scan: only the latest follows
      fx = {$urandom, $urandom}; fa = {$urandom, $urandom}; fb = {$urandom, $urandom};
      load(fx);
      wait_words(2, 500);
      load(fa);
      idle(3);
      load(fb);
      exp_frame(fx); exp_frame(fb);
      fd0 = fd_cnt;
      wait_fd(fd0 + 2, 5000);
      idle(50);
      chk("fdone_two", fd_cnt - fd0, 2);
      cmp_words("latest");

      // Load on the same cycle idle consumes the flag
      fa = {$urandom, $urandom}; fb = {$urandom, $urandom};
      @(negedge sys_clk); frame = fa; frame_load = 1'b1;
      @(negedge sys_clk); frame = fb;
      @(negedge sys_clk); frame_load = 1'b0; #1;
      exp_frame(fa); exp_frame(fb);
      fd0 = fd_cnt;
      wait_fd(fd0 + 2, 5000);
      idle(50);
      cmp_words("samecyc");

      // Reset in the middle of row 3
      f = {$urandom, $urandom};
      load(f);
      wait_words(4, 1000);
      idle(5);
      #2 rst = 1'b1;
      #1 chk_reset_outs("midrst");
      idle(2);
      got_q.delete(); low_q.delete();
      @(negedge sys_clk); rst = 1'b0;
      fd0 = fd_cnt;
      exp_init();
      wait_init(3000);
      idle(300);
      chk("midrst_noscan", fd_cnt - fd0, 0);
      cmp_words("rstinit");

      // Watchdog: busy never rises; a frame loaded during the hang survives the restart
      drv_en = 1'b0;
      f  = {$urandom, $urandom};
      fx = {$urandom, $urandom};
      load(f);
      wait_words(1, 200);
      idle(10);
      load(fx);
      wait_err(TO_CYC + 500);
      chk("wd_latency", err_cyc - rise_cyc, TO_CYC);
      chk("wd_str", spi_str, 0);
      chk("wd_init", init_done, 0);
      drv_en = 1'b1;
      exp_q.push_back({8'h01, f[7:0]});
      exp_init();
      exp_frame(fx);
      fd0 = fd_cnt;
      wait_fd(fd0 + 1, 5000);
      idle(50);
      chk("wd_err_sticky", err, 1);
      chk("wd_init_again", init_done, 1);
      cmp_words("wdog");

      chk("addr_data_stable", stab_err, 0);

      @(negedge sys_clk); rst = 1'b1;
      idle(1);
      chk("err_clear", err, 0);
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
